// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-memory controller.
// Optional DMEM_STALL_CNT_EN adds a saturating stall-cycle counter (dmem_stall_cnt, stall_cnt_clr).
module ex_mem_wb_pipe #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_RegWrite,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic [1:0]      ex_MemtoReg,
  input  logic [4:0]      ex_Rd,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc_plus4,
  output logic            mem_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_err,
  output logic            EX_MEM_RegWrite,
  output logic [4:0]      EX_MEM_RegisterRd,
  output logic            MEM_WB_RegWrite,
  output logic [4:0]      MEM_WB_RegisterRd,
  output logic [XLEN-1:0] wb_data
`ifdef DMEM_STALL_CNT_EN
  ,
  output logic [31:0]     dmem_stall_cnt,
  input  logic            stall_cnt_clr
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ABORT = 2'd2} state_t;

  // Handshake: dmem_req stays high with addr/we/wdata stable until the cycle
  // dmem_ack is seen; ack in a cycle without req has no effect.
  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            pending, abort;

  logic            exm_valid, exm_rw, exm_mr, exm_mw;
  logic [1:0]      exm_mtr;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_alu, exm_rs2, exm_pc4;

  logic            mwb_valid, mwb_rw;
  logic [4:0]      mwb_rd;
  logic [XLEN-1:0] wb_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_valid <= 1'b0;
      exm_rw    <= 1'b0;
      exm_mr    <= 1'b0;
      exm_mw    <= 1'b0;
      exm_mtr   <= 2'b00;
      exm_rd    <= 5'd0;
      exm_alu   <= '0;
      exm_rs2   <= '0;
      exm_pc4   <= '0;
    end else if (!mem_busy) begin
      exm_valid <= ex_valid;
      exm_rw    <= ex_RegWrite & (ex_Rd != 5'd0);
      exm_mr    <= ex_MemRead;
      exm_mw    <= ex_MemWrite;
      exm_mtr   <= ex_MemtoReg;
      exm_rd    <= ex_Rd;
      exm_alu   <= ex_alu_result;
      exm_rs2   <= ex_rs2_data;
      exm_pc4   <= ex_pc_plus4;
    end
  end

  assign pending = exm_valid & (exm_mr | exm_mw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (pending && !dmem_ack) next_state = S_WAIT;
      S_WAIT: begin
        if (dmem_ack)                        next_state = S_IDLE;
        else if (cnt == CW'(TIMEOUT - 1))    next_state = S_ABORT;
      end
      S_ABORT: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    abort      = (state == S_ABORT);
    dmem_err   = abort;
    dmem_req   = pending & !abort;
    mem_busy   = pending & !dmem_ack & !abort;
    dmem_we    = dmem_req & exm_mw;
    dmem_addr  = dmem_req ? exm_alu : '0;
    dmem_wdata = dmem_req ? exm_rs2 : '0;
  end

  // cnt counts request cycles already spent waiting; IDLE covers the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  cnt <= (pending && !dmem_ack) ? CW'(1) : '0;
        S_WAIT:  cnt <= (dmem_ack || next_state == S_ABORT) ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    case (exm_mtr)
      2'b01:   wb_mux = dmem_rdata;
      2'b10:   wb_mux = exm_pc4;
      default: wb_mux = exm_alu;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mwb_valid <= 1'b0;
      mwb_rw    <= 1'b0;
      mwb_rd    <= 5'd0;
      wb_data   <= '0;
    end else if (!mem_busy) begin
      mwb_valid <= exm_valid;
      mwb_rw    <= exm_rw & !abort;
      mwb_rd    <= exm_rd;
      wb_data   <= wb_mux;
    end else begin
      mwb_valid <= 1'b0;
      mwb_rw    <= 1'b0;
    end
  end

  assign EX_MEM_RegWrite   = exm_valid & exm_rw;
  assign EX_MEM_RegisterRd = exm_rd;
  assign MEM_WB_RegWrite   = mwb_valid & mwb_rw;
  assign MEM_WB_RegisterRd = mwb_rd;

`ifdef DMEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               dmem_stall_cnt <= '0;
    else if (stall_cnt_clr)                dmem_stall_cnt <= '0;
    else if (mem_busy && dmem_stall_cnt != 32'hFFFF_FFFF)
                                           dmem_stall_cnt <= dmem_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: directed and random instruction streams against a
// transaction-level model of the MEM stage (request-cycle counting, writeback queue).
module tb_ex_mem_wb_pipe;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk, rst;
  logic            ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic [1:0]      ex_MemtoReg;
  logic [4:0]      ex_Rd;
  logic [XLEN-1:0] ex_alu_result, ex_rs2_data, ex_pc_plus4;
  logic            mem_busy, dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic            EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [4:0]      EX_MEM_RegisterRd, MEM_WB_RegisterRd;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0]     dmem_stall_cnt;
  logic            stall_cnt_clr;
`endif

  ex_mem_wb_pipe #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
`ifdef DMEM_STALL_CNT_EN
    .dmem_stall_cnt(dmem_stall_cnt),
    .stall_cnt_clr(stall_cnt_clr),
`endif
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Rd(ex_Rd),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_pc_plus4(ex_pc_plus4),
    .mem_busy(mem_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RegisterRd(MEM_WB_RegisterRd),
    .wb_data(wb_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, rw, mr, mw;
    logic [1:0]  mtr;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, pc4, rdata;
  } instr_t;

  int compared = 0;
  int mismatched = 0;

  // scoreboard: {rd, data} of every write that must reach the register file
  logic [36:0] exp_q[$];

  // model of the instruction sitting in the MEM stage
  instr_t m, cur;
  int     m_lat, cur_lat, m_k, exp_stall;
  bit     m_abort, accepted;
  logic        exp_wb_rw;
  logic [4:0]  exp_wb_rd;
  logic [31:0] exp_wb_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(bit v, bit rw, bit mr, bit mw, logic [1:0] mtr, logic [4:0] rd,
                                logic [31:0] alu, logic [31:0] rs2, logic [31:0] pc4,
                                logic [31:0] rdata);
    instr_t i;
    i.valid = v; i.rw = rw; i.mr = mr; i.mw = mw; i.mtr = mtr; i.rd = rd;
    i.alu = alu; i.rs2 = rs2; i.pc4 = pc4; i.rdata = rdata;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    int k;
    k = $urandom_range(0, 3);
    return mk($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, k == 2, k == 3,
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom, $urandom);
  endfunction

  task automatic model_reset();
    m = '0; cur = '0; m_lat = 1; cur_lat = 1; m_k = 0; m_abort = 0; exp_stall = 0;
    exp_wb_rw = 0; exp_wb_rd = 0; exp_wb_data = 0;
    exp_q.delete();
  endtask

  task automatic drive_cur();
    ex_valid = cur.valid; ex_RegWrite = cur.rw; ex_MemRead = cur.mr; ex_MemWrite = cur.mw;
    ex_MemtoReg = cur.mtr; ex_Rd = cur.rd;
    ex_alu_result = cur.alu; ex_rs2_data = cur.rs2; ex_pc_plus4 = cur.pc4;
  endtask

  // one clock cycle: drive, check, then advance the model past the coming edge
  task automatic step();
    bit op, e_req, e_busy, e_err, ack, complete, kill;
    logic [31:0] rdata, sel;
    @(negedge clk);
    drive_cur();
    op = m.valid & (m.mr | m.mw);
    e_req = 0; e_busy = 0; e_err = 0; complete = 1; kill = 0;
    ack = $urandom_range(0, 1) != 0;
    rdata = $urandom;
    if (op) begin
      rdata = m.rdata;
      if (m_abort) begin
        e_err = 1; kill = 1;
      end else begin
        m_k++;
        e_req = 1;
        ack = (m_k == m_lat);
        if (!ack) begin
          e_busy = 1; complete = 0;
          if (m_k == TIMEOUT) m_abort = 1;
        end
      end
    end
    dmem_ack = ack; dmem_rdata = rdata;
    #1;
    chk("dmem_req", dmem_req, e_req);
    chk("mem_busy", mem_busy, e_busy);
    chk("dmem_err", dmem_err, e_err);
    if (e_req) begin
      chk("dmem_addr", dmem_addr, m.alu);
      chk("dmem_we", dmem_we, m.mw);
      if (m.mw) chk("dmem_wdata", dmem_wdata, m.rs2);
    end
    chk("ex_mem_rw", EX_MEM_RegWrite, m.valid & m.rw & (m.rd != 0));
    chk("ex_mem_rd", EX_MEM_RegisterRd, m.rd);
    chk("mem_wb_rw", MEM_WB_RegWrite, exp_wb_rw);
    chk("mem_wb_rd", MEM_WB_RegisterRd, exp_wb_rd);
    chk("wb_data", wb_data, exp_wb_data);
    if (MEM_WB_RegWrite === 1'b1) begin
      if (exp_q.size() > 0) chk("wb_commit", {MEM_WB_RegisterRd, wb_data}, exp_q.pop_front());
      else chk("wb_unexpected", MEM_WB_RegWrite, 0);
    end
`ifdef DMEM_STALL_CNT_EN
    chk("stall_cnt", dmem_stall_cnt, exp_stall);
`endif
    if (e_busy) exp_stall++;
    accepted = complete;
    if (complete) begin
      case (m.mtr)
        2'b01:   sel = rdata;
        2'b10:   sel = m.pc4;
        default: sel = m.alu;
      endcase
      exp_wb_rw = m.valid & m.rw & (m.rd != 0) & !kill;
      exp_wb_rd = m.rd;
      exp_wb_data = sel;
      if (exp_wb_rw) exp_q.push_back({m.rd, sel});
      m = cur; m_lat = cur_lat; m_k = 0; m_abort = 0;
    end else begin
      exp_wb_rw = 0;
    end
  endtask

  // present an instruction and clock until the stage accepts it
  task automatic run(input instr_t i, input int lat);
    cur = i; cur_lat = lat;
    do step(); while (!accepted);
  endtask

  task automatic bubbles(input int n);
    for (int j = 0; j < n; j++) run(mk(0, 0, 0, 0, 2'b00, 5'd0, $urandom, $urandom, $urandom, 0), 1);
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 0; dmem_rdata = 0;
`ifdef DMEM_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    model_reset();
    drive_cur();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_err", dmem_err, 0);
    chk("rst_ex_mem_rw", EX_MEM_RegWrite, 0);
    chk("rst_mem_wb_rw", MEM_WB_RegWrite, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b0;

    // directed: ALU op, 3-cycle load, zero-wait store, timeout, rd0, invalid, ack on last cycle
    run(mk(1, 1, 0, 0, 2'b00, 5'd5, 32'h10, 32'h0, 32'h4, 32'h0), 1);
    bubbles(2);
    run(mk(1, 1, 1, 0, 2'b01, 5'd7, 32'h100, 32'h0, 32'h8, 32'hDEADBEEF), 3);
    bubbles(2);
    run(mk(1, 0, 0, 1, 2'b00, 5'd0, 32'h20, 32'hAA, 32'hC, 32'h0), 1);
    bubbles(2);
    run(mk(1, 1, 1, 0, 2'b01, 5'd9, 32'h200, 32'h0, 32'h10, 32'h1234), 0);
    run(mk(1, 1, 0, 0, 2'b10, 5'd11, 32'h30, 32'h0, 32'h14, 32'h0), 1);
    run(mk(1, 1, 0, 0, 2'b00, 5'd0, 32'h40, 32'h0, 32'h18, 32'h0), 1);
    run(mk(0, 1, 0, 0, 2'b00, 5'd3, 32'h50, 32'h0, 32'h1C, 32'h0), 1);
    run(mk(1, 1, 1, 0, 2'b01, 5'd12, 32'h300, 32'h0, 32'h20, 32'hCAFEF00D), TIMEOUT);
    run(mk(1, 1, 1, 0, 2'b01, 5'd13, 32'h304, 32'h0, 32'h24, 32'h11111111), 1);
    run(mk(1, 1, 0, 1, 2'b11, 5'd14, 32'h308, 32'h55, 32'h28, 32'h0), 2);
    bubbles(2);

    // random stream
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 19);
      run(rnd_instr(), (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 4));
    end
    bubbles(3);
    chk("wb_q_drained", exp_q.size(), 0);

    // reset in the middle of a waiting load
    run(mk(1, 1, 1, 0, 2'b01, 5'd20, 32'h400, 32'h0, 32'h30, 32'h0), 0);
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", dmem_req, 0);
    chk("rst_mid_busy", mem_busy, 0);
    chk("rst_mid_ex_mem_rw", EX_MEM_RegWrite, 0);
    chk("rst_mid_mem_wb_rw", MEM_WB_RegWrite, 0);
    model_reset();
    drive_cur();
    @(negedge clk);
    rst = 1'b0;
    bubbles(2);
    run(mk(1, 1, 1, 0, 2'b01, 5'd21, 32'h500, 32'h0, 32'h34, 32'h89ABCDEF), 2);
    bubbles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
